huff_decoder: RTL and testbench
===============================

Name: huff_decoder

Overview:
- Receive side of the Huffman link. Decodes a serial bitstream back into 7-bit characters.
- Uses the code table that huff_encoder produces: encoded_value, encoded_mask and character, packed for up to 5 symbols.
- Sits downstream of the channel and upstream of the character sink. Emits one char_valid pulse per decoded symbol.

Parameters:
- NUM_SYMS, 5, number of table entries.
- CODE_W, 5, maximum code length in bits. Also the width of each value/mask slot.
- CHAR_W, 7, character width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- table_en  in  1  one-cycle strobe that loads the code table.
- encoded_value  in  NUM_SYMS*CODE_W  code values. Entry i is at [(NUM_SYMS-1-i)*CODE_W +: CODE_W]. Code bit 0 (first received) is at position len-1.
- encoded_mask  in  NUM_SYMS*CODE_W  per-entry mask = (1<<len)-1. A mask of 0 marks the entry unused.
- character  in  NUM_SYMS*CHAR_W  entry i is at [(NUM_SYMS-1-i)*CHAR_W +: CHAR_W].
- bit_in  in  1  serial code bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_ready  out  1  decoder accepts a bit this cycle.
- char_out  out  CHAR_W  decoded character.
- char_valid  out  1  one-cycle pulse; char_out is valid.
- err  out  1  sticky: no code matched within CODE_W bits.
- sym_count  out  8  count of decoded symbols; wraps 255->0.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; shift accumulator acc=0; bit count len=0.
  - table cleared: all masks 0.
  - char_out=0, char_valid=0, err=0, sym_count=0, bit_ready=0.
- States: IDLE, RUN, ERR.
  - IDLE: bit_ready=0, bits ignored. table_en -> latch all three table buses, acc=0, len=0, go to RUN next cycle.
  - RUN: bit_ready=1. On bit_valid:
    - acc <= {acc[CODE_W-2:0], bit_in}; len <= len+1.
    - Match check uses the updated acc/len, combinationally, in the same cycle. Entry i matches when mask_i != 0, popcount(mask_i) == len+1, and (acc_next & mask_i) == value_i.
    - On match: char_out <= character_i and char_valid=1 on the next cycle (1-cycle latency from the accepting edge); acc and len cleared; sym_count increments.
    - Multiple matches (malformed table): the lowest index wins.
    - No match and len+1 == CODE_W: err <= 1, go to ERR, no char_valid.
  - ERR: bit_ready=0, bits ignored, err held at 1. table_en -> reload table, clear err/acc/len, go to RUN.
- table_en in RUN:
  - Has priority over a bit arriving in the same cycle; that bit is dropped and not consumed.
  - A partially received code is discarded (acc=0, len=0). sym_count is not cleared.
- All entries unused (all masks 0): every bit sequence leads to err after CODE_W bits.
- char_valid is a pulse only. char_out holds its last value until the next match.
- Back-to-back: a symbol may complete on every accepted bit, e.g. a stream of 1-bit codes gives char_valid on consecutive cycles.
- Reset mid-symbol: all state is discarded immediately and the table is invalidated; table_en is required again.
- No internal buffering: the sink must take char_out within the char_valid cycle.

Test Plan:
- Test table T (characters hex):
  - entry0 char 0x41 value 00000 mask 00001 (code "0")
  - entry1 char 0x42 value 00010 mask 00011 (code "10")
  - entry2 char 0x43 value 00110 mask 00111 (code "110")
  - entry3 char 0x44 value 00111 mask 00111 (code "111")
  - entry4 mask 0 (unused)
- 1: Load T, send bits 0,1,0,1,1,0,1,1,1 one per cycle -> char_valid pulses with char_out 0x41, 0x42, 0x43, 0x44, each one cycle after its last bit; sym_count = 4.
- 2: bit_valid toggled 1/0 with bits 1,0 -> a single 0x42 pulse one cycle after the second accepted bit; idle cycles leave acc unchanged.
- 3: Table with a single entry char 0x5A, mask 00001, value 00001; send 0 x5 -> err=1 after the 5th bit, bit_ready=0, no char_valid; then table_en with T -> err=0, RUN; bit 0 -> 0x41.
- 4: Send 1,1 with T, then pulse table_en together with bit 0 -> partial code discarded, that bit dropped; subsequent 0 -> 0x41.
- 5: Assert reset after bits 1,1 -> all outputs 0, state IDLE; bits ignored until table_en.
- 6: Decode 256 symbols "0" -> sym_count wraps to 0; char_valid seen 256 times.

Source files
------------

// File: rtl/huff_decoder.sv
// Serial Huffman decoder: shifts code bits into an accumulator and matches the
// partial code against a loaded table, emitting one character per completed code.
module huff_decoder #(
    parameter int NUM_SYMS = 5,
    parameter int CODE_W   = 5,
    parameter int CHAR_W   = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         table_en,
    input  logic [NUM_SYMS*CODE_W-1:0]   encoded_value,
    input  logic [NUM_SYMS*CODE_W-1:0]   encoded_mask,
    input  logic [NUM_SYMS*CHAR_W-1:0]   character,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    output logic [CHAR_W-1:0]            char_out,
    output logic                         char_valid,
    output logic                         err,
    output logic [7:0]                   sym_count
);

    localparam int LEN_W = $clog2(CODE_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    logic [1:0]        state;
    logic [CODE_W-1:0] acc;
    logic [LEN_W-1:0]  len;

    logic [CODE_W-1:0] tbl_value [NUM_SYMS];
    logic [CODE_W-1:0] tbl_mask  [NUM_SYMS];
    logic [CHAR_W-1:0] tbl_char  [NUM_SYMS];

    logic [CODE_W-1:0] acc_next;
    logic [LEN_W-1:0]  len_next;
    logic              hit;
    logic [CHAR_W-1:0] hit_char;

    function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] m);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int b = 0; b < CODE_W; b++) begin
            n = n + LEN_W'(m[b]);
        end
        return n;
    endfunction

    function automatic logic entry_match(input logic [CODE_W-1:0] value,
                                         input logic [CODE_W-1:0] mask,
                                         input logic [CODE_W-1:0] code,
                                         input logic [LEN_W-1:0]  code_len);
        return (mask != '0) && (popcount(mask) == code_len) && ((code & mask) == value);
    endfunction

    assign acc_next  = {acc[CODE_W-2:0], bit_in};
    assign len_next  = len + LEN_W'(1);
    assign bit_ready = (state == RUN);

    // Scan from the top index down so the lowest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_char = '0;
        for (int i = NUM_SYMS - 1; i >= 0; i--) begin
            if (entry_match(tbl_value[i], tbl_mask[i], acc_next, len_next)) begin
                hit      = 1'b1;
                hit_char = tbl_char[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            len        <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            err        <= 1'b0;
            sym_count  <= 8'd0;
            for (int i = 0; i < NUM_SYMS; i++) begin
                tbl_value[i] <= '0;
                tbl_mask[i]  <= '0;
                tbl_char[i]  <= '0;
            end
        end else begin
            char_valid <= 1'b0;
            // A table load wins over any bit offered in the same cycle.
            if (table_en) begin
                for (int i = 0; i < NUM_SYMS; i++) begin
                    tbl_value[i] <= encoded_value[(NUM_SYMS-1-i)*CODE_W +: CODE_W];
                    tbl_mask[i]  <= encoded_mask[(NUM_SYMS-1-i)*CODE_W +: CODE_W];
                    tbl_char[i]  <= character[(NUM_SYMS-1-i)*CHAR_W +: CHAR_W];
                end
                acc   <= '0;
                len   <= '0;
                err   <= 1'b0;
                state <= RUN;
            end else if (state == RUN && bit_valid) begin
                if (hit) begin
                    char_out   <= hit_char;
                    char_valid <= 1'b1;
                    acc        <= '0;
                    len        <= '0;
                    sym_count  <= sym_count + 8'd1;
                end else if (len_next == LEN_W'(CODE_W)) begin
                    err   <= 1'b1;
                    state <= ERR;
                    acc   <= '0;
                    len   <= '0;
                end else begin
                    acc <= acc_next;
                    len <= len_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: table loads, decoding, error, flush, reset and wrap.
module tb_huff_decoder;

    localparam int NUM_SYMS = 5;
    localparam int CODE_W   = 5;
    localparam int CHAR_W   = 7;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       table_en;
    logic [NUM_SYMS*CODE_W-1:0] encoded_value;
    logic [NUM_SYMS*CODE_W-1:0] encoded_mask;
    logic [NUM_SYMS*CHAR_W-1:0] character;
    logic                       bit_in;
    logic                       bit_valid;
    logic                       bit_ready;
    logic [CHAR_W-1:0]          char_out;
    logic                       char_valid;
    logic                       err;
    logic [7:0]                 sym_count;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [24:0] T_VALUE = {5'b00000, 5'b00010, 5'b00110, 5'b00111, 5'b00000};
    localparam logic [24:0] T_MASK  = {5'b00001, 5'b00011, 5'b00111, 5'b00111, 5'b00000};
    localparam logic [34:0] T_CHAR  = {7'h41, 7'h42, 7'h43, 7'h44, 7'h00};

    huff_decoder #(.NUM_SYMS(NUM_SYMS), .CODE_W(CODE_W), .CHAR_W(CHAR_W)) dut (
        .clk(clk), .reset(reset), .table_en(table_en),
        .encoded_value(encoded_value), .encoded_mask(encoded_mask), .character(character),
        .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .char_out(char_out), .char_valid(char_valid), .err(err), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [24:0] v, input logic [24:0] m, input logic [34:0] c);
        encoded_value = v;
        encoded_mask  = m;
        character     = c;
        table_en      = 1'b1;
        tick();
        table_en      = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (char_out !== 7'h00) begin n_fail++; $display("FAIL reset_char_out: got %h want 00", char_out); end
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid: got %b want 0", char_valid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (sym_count !== 8'd0) begin n_fail++; $display("FAIL reset_sym_count: got %0d want 0", sym_count); end
        n_cmp++; if (bit_ready !== 1'b0) begin n_fail++; $display("FAIL reset_bit_ready: got %b want 0", bit_ready); end
        reset = 1'b1;
        tick();
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_bits: char_valid got %b want 0", char_valid); end
    endtask

    task automatic test_stream();
        logic       bits [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       vld  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [6:0] chr  [9] = '{7'h41, 7'h00, 7'h42, 7'h00, 7'h00, 7'h43, 7'h00, 7'h00, 7'h44};
        load_table(T_VALUE, T_MASK, T_CHAR);
        n_cmp++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL run_bit_ready: got %b want 1", bit_ready); end
        for (int k = 0; k < 9; k++) begin
            send_bit(bits[k]);
            n_cmp++; if (char_valid !== vld[k]) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want %b", k, char_valid, vld[k]); end
            if (vld[k]) begin
                n_cmp++; if (char_out !== chr[k]) begin n_fail++; $display("FAIL stream_char[%0d]: got %h want %h", k, char_out, chr[k]); end
            end
        end
        n_cmp++; if (sym_count !== 8'd4) begin n_fail++; $display("FAIL stream_sym_count: got %0d want 4", sym_count); end
    endtask

    task automatic test_gapped();
        send_bit(1'b1);
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL gap_first_bit: char_valid got %b want 0", char_valid); end
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        tick();
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL gap_idle: char_valid got %b want 0", char_valid); end
        n_cmp++; if (char_out !== 7'h44) begin n_fail++; $display("FAIL gap_char_hold: got %h want 44", char_out); end
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", char_valid); end
        n_cmp++; if (char_out !== 7'h42) begin n_fail++; $display("FAIL gap_char: got %h want 42", char_out); end
        tick();
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL gap_pulse_end: got %b want 0", char_valid); end
        n_cmp++; if (char_out !== 7'h42) begin n_fail++; $display("FAIL gap_char_after: got %h want 42", char_out); end
    endtask

    task automatic test_error();
        logic any_valid;
        any_valid = 1'b0;
        load_table({5'b00001, 20'd0}, {5'b00001, 20'd0}, {7'h5A, 28'd0});
        for (int k = 0; k < 4; k++) begin
            send_bit(1'b0);
            any_valid |= char_valid;
            n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early[%0d]: got %b want 0", k, err); end
        end
        send_bit(1'b0);
        any_valid |= char_valid;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        n_cmp++; if (bit_ready !== 1'b0) begin n_fail++; $display("FAIL err_bit_ready: got %b want 0", bit_ready); end
        n_cmp++; if (any_valid !== 1'b0) begin n_fail++; $display("FAIL err_no_valid: got %b want 0", any_valid); end
        send_bit(1'b1);
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL err_ignores_bits: got %b want 0", char_valid); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        load_table(T_VALUE, T_MASK, T_CHAR);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        n_cmp++; if (bit_ready !== 1'b1) begin n_fail++; $display("FAIL err_rerun: bit_ready got %b want 1", bit_ready); end
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b1 || char_out !== 7'h41) begin n_fail++; $display("FAIL err_recover: got %b/%h want 1/41", char_valid, char_out); end
        n_cmp++; if (sym_count !== 8'd6) begin n_fail++; $display("FAIL err_sym_count: got %0d want 6", sym_count); end
    endtask

    task automatic test_flush();
        send_bit(1'b1);
        send_bit(1'b1);
        encoded_value = T_VALUE;
        encoded_mask  = T_MASK;
        character     = T_CHAR;
        table_en  = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        tick();
        table_en  = 1'b0;
        bit_valid = 1'b0;
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bit_dropped: got %b want 0", char_valid); end
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b1 || char_out !== 7'h41) begin n_fail++; $display("FAIL flush_decode: got %b/%h want 1/41", char_valid, char_out); end
        n_cmp++; if (sym_count !== 8'd7) begin n_fail++; $display("FAIL flush_sym_count: got %0d want 7", sym_count); end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        tick();
        n_cmp++; if (char_out !== 7'h00 || char_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", char_out, char_valid, err); end
        n_cmp++; if (sym_count !== 8'd0 || bit_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_count_ready: got %0d/%b want 0/0", sym_count, bit_ready); end
        reset = 1'b1;
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got %b want 0", char_valid); end
        load_table(T_VALUE, T_MASK, T_CHAR);
        send_bit(1'b0);
        n_cmp++; if (char_valid !== 1'b1 || char_out !== 7'h41) begin n_fail++; $display("FAIL midreset_decode: got %b/%h want 1/41", char_valid, char_out); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        load_table(T_VALUE, T_MASK, T_CHAR);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (char_valid === 1'b1 && char_out === 7'h41) pulses++;
            if (k == 254) begin
                n_cmp++; if (sym_count !== 8'd255) begin n_fail++; $display("FAIL b2b_count_255: got %0d want 255", sym_count); end
            end
        end
        bit_valid = 1'b0;
        n_cmp++; if (pulses !== 256) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 256", pulses); end
        n_cmp++; if (sym_count !== 8'd0) begin n_fail++; $display("FAIL b2b_wrap: got %0d want 0", sym_count); end
        tick();
        n_cmp++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %b want 0", char_valid); end
    endtask

    initial begin
        reset         = 1'b0;
        table_en      = 1'b0;
        encoded_value = '0;
        encoded_mask  = '0;
        character     = '0;
        bit_in        = 1'b0;
        bit_valid     = 1'b0;
        test_reset();
        test_stream();
        test_gapped();
        test_error();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
